// File: rtl/filter_pkg.sv
// Shared types and fixed-point constants for the one-pole IIR filter datapath.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic {
        LOWPASS  = 1'b0,
        HIGHPASS = 1'b1
    } mode_e;

    localparam int SAT_MAX = 2047;
    localparam int SAT_MIN = -2047;
    localparam int Q_SHIFT = 11;
    localparam int Q_ONE   = 1 << Q_SHIFT;

    // Symmetric clamp so |y| always fits in DW-1 magnitude bits.
    function automatic int sat(input int v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

endpackage

// File: rtl/filter_iir_step.sv
// One IIR step, purely combinational: lp = sat((A*y_prev + (1-A)*x) >>> 11),
// y = lp (low-pass) or sat(x - lp) (high-pass).
module filter_iir_step
    import filter_pkg::*;
#(
    parameter int DW   = 12,
    parameter int COEF = 1843
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y_prev,
    input  mode_e                mode,
    output logic signed [DW-1:0] y,
    output logic signed [DW-1:0] lp
);

    int acc;

    // Arithmetic shift on a signed int floors toward minus infinity.
    always_comb begin
        acc = COEF * int'(y_prev) + (Q_ONE - COEF) * int'(x);
        lp  = DW'(sat(acc >>> Q_SHIFT));
        y   = (mode == HIGHPASS) ? DW'(sat(int'(x) - int'(lp))) : lp;
    end

endmodule

// File: rtl/filter_sequencer.sv
// Frame sequencer: reads N_SAMPLES from sample RAM, filters each, writes filtered RAM.
// Optional FILTER_SEQ_PEAK_EN adds peak_abs = max |wr_data| over the last frame.
module filter_sequencer
    import filter_pkg::*;
#(
    parameter int N_SAMPLES = 256,
    parameter int DW        = 12,
    parameter int AW        = 8,
    parameter int COEF      = 1843
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic signed [DW-1:0] rd_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic signed [DW-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
`ifdef FILTER_SEQ_PEAK_EN
    ,
    output logic [DW-2:0]        peak_abs
`endif
);

    localparam logic [AW-1:0] LAST = AW'(N_SAMPLES - 1);

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic                 rd_en_q, rd_en_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic                 pend_q, pend_d;
    logic [AW-1:0]        pend_addr_q, pend_addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic signed [DW-1:0] wr_data_q, wr_data_d;
    logic signed [DW-1:0] y_prev_q, y_prev_d;
    logic                 overrun_q, overrun_d;
    logic                 start_ok, kill;
    logic signed [DW-1:0] y_step, lp_step;

    filter_iir_step #(
        .DW  (DW),
        .COEF(COEF)
    ) u_step (
        .x     (rd_data),
        .y_prev(y_prev_q),
        .mode  (mode_q),
        .y     (y_step),
        .lp    (lp_step)
    );

    assign start_ok = (state_q == IDLE) && start && !abort;
    assign kill     = abort && ((state_q == RUN) || (state_q == DRAIN));

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        y_prev_d    = y_prev_q;
        overrun_d   = overrun_q;
        // pend marks a read issued last cycle, so rd_data holds its sample now.
        pend_d      = rd_en_q && !kill;
        pend_addr_d = rd_addr_q;
        wr_en_d     = pend_q && !kill;
        if (pend_q) begin
            wr_addr_d = pend_addr_q;
            wr_data_d = y_step;
            y_prev_d  = lp_step;
        end
        if (start && (state_q != IDLE)) overrun_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d   = RUN;
                    mode_d    = mode_e'(mode);
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    y_prev_d  = '0;
                    overrun_d = 1'b0;
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                    rd_en_d = 1'b0;
                end else if (rd_addr_q == LAST) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (kill) state_d = IDLE;
                else if (wr_en_q && (wr_addr_q == LAST)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= LOWPASS;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            y_prev_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            y_prev_q    <= y_prev_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef FILTER_SEQ_PEAK_EN
    logic [DW-2:0] peak_q, peak_d;
    logic [DW-1:0] wr_abs;

    // Saturation keeps wr_data above -2^(DW-1), so negation cannot overflow.
    assign wr_abs = wr_data_q[DW-1] ? -wr_data_q : wr_data_q;

    always_comb begin
        peak_d = peak_q;
        if (start_ok) peak_d = '0;
        else if (wr_en_q && (wr_abs > {1'b0, peak_q})) peak_d = wr_abs[DW-2:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign peak_abs = peak_q;
`endif

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_filter_sequencer.sv
// Bench for filter_sequencer: frame-level reference model plus per-cycle output compare.
module tb_filter_sequencer;

    localparam int N = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              mode;
    logic              rd_en;
    logic [7:0]        rd_addr;
    logic signed [11:0] rd_data;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic signed [11:0] wr_data;
    logic              busy;
    logic              done;
    logic              overrun;
`ifdef FILTER_SEQ_PEAK_EN
    logic [10:0]       peak_abs;
`endif

    filter_sequencer #(
        .N_SAMPLES(N),
        .DW       (12),
        .AW       (8),
        .COEF     (1843)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .mode    (mode),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
`ifdef FILTER_SEQ_PEAK_EN
        ,
        .peak_abs(peak_abs)
`endif
    );

    initial forever #5 clk = ~clk;

    // Sample RAM with one cycle of read latency.
    int mem [N];
    always @(posedge clk) if (rd_en) rd_data <= 12'(mem[rd_addr]);

    // ---------------- reference model ----------------
    bit m_act = 1'b0;
    int m_k   = 0;
    bit m_ovr = 1'b0;
    int m_exp [N];
    int m_peak = 0;

    function automatic int floor_div2048(input int v);
        if (v >= 0) return v / 2048;
        return -((-v + 2047) / 2048);
    endfunction

    function automatic int clampv(input int v);
        return (v > 2047) ? 2047 : ((v < -2047) ? -2047 : v);
    endfunction

    task automatic build_expected(input bit md);
        int yp = 0;
        int lpv, yv;
        m_peak = 0;
        for (int n = 0; n < N; n++) begin
            lpv = clampv(floor_div2048(1843 * yp + 205 * mem[n]));
            yv  = md ? clampv(mem[n] - lpv) : lpv;
            m_exp[n] = yv;
            if ((yv < 0 ? -yv : yv) > m_peak) m_peak = (yv < 0 ? -yv : yv);
            yp = lpv;
        end
    endtask

    // m_k is the cycle index (1 = first cycle after the accepting edge).
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_act = 1'b0;
            m_ovr = 1'b0;
            m_k   = 0;
        end else if (m_act) begin
            if (start) m_ovr = 1'b1;
            if (abort && m_k <= 258) m_act = 1'b0;
            else begin
                m_k++;
                if (m_k == 260) m_act = 1'b0;
            end
        end else if (start && !abort) begin
            m_act = 1'b1;
            m_k   = 1;
            m_ovr = 1'b0;
            build_expected(mode);
        end
    end

    // ---------------- compare ----------------
    int n_chk  = 0;
    int n_fail = 0;
    int tcase  = 0;
    int got [N];
    bit e_rd, e_wr, e_busy, e_done, flag;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        e_busy = m_act && m_k <= 258;
        e_rd   = m_act && m_k <= 256;
        e_wr   = m_act && m_k >= 3 && m_k <= 258;
        e_done = m_act && m_k == 259;
        check("rd_en", int'(rd_en), int'(e_rd));
        check("wr_en", int'(wr_en), int'(e_wr));
        check("busy", int'(busy), int'(e_busy));
        check("done", int'(done), int'(e_done));
        check("overrun", int'(overrun), int'(m_ovr));
        if (e_rd) check("rd_addr", int'(rd_addr), m_k - 1);
        if (e_wr) begin
            check("wr_addr", int'(wr_addr), m_k - 3);
            check("wr_data", int'(wr_data), m_exp[m_k-3]);
        end
        if (wr_en) got[wr_addr] = int'(wr_data);
        if (e_done) begin
`ifdef FILTER_SEQ_PEAK_EN
            check("peak_abs", int'(peak_abs), m_peak);
            if (tcase == 6) check("peak_impulse", int'(peak_abs), 200);
`endif
            case (tcase)
                1: begin
                    check("lp_y0", got[0], 100);
                    check("lp_y1", got[1], 190);
                    flag = 1'b1;
                    for (int n = 1; n < N; n++) if (got[n] < got[n-1]) flag = 1'b0;
                    check("lp_monotonic", int'(flag), 1);
                    check("lp_settled", int'(got[255] >= 990 && got[255] <= 1000), 1);
                end
                2: begin
                    check("hp_y0", got[0], 900);
                    check("hp_y1", got[1], 810);
                    check("hp_decayed", int'(got[255] >= 0 && got[255] <= 10), 1);
                end
                3: begin
                    check("alt_y0", got[0], 1843);
                    check("alt_y1", got[1], -2025);
                    flag = 1'b1;
                    for (int n = 0; n < N; n++) if (got[n] > 2047 || got[n] < -2047) flag = 1'b0;
                    check("alt_in_range", int'(flag), 1);
                end
                4: check("restart_y0", got[0], 100);
                5: begin
                    check("overrun_at_done", int'(overrun), 1);
                    check("overrun_frame_y0", got[0], 100);
                end
                default: ;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge with the DUT idle; arguments are cycle indices (0 = none).
    task automatic frame(input bit md, input int ab_c, input int st_c, input int mc);
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 262; c++) begin
            abort = (c == ab_c);
            start = (c == st_c);
            if (c == mc) mode = ~mode;
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic fill_const(input int v);
        for (int n = 0; n < N; n++) mem[n] = v;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fill_const(1000);
        tcase = 1; frame(1'b0, 0, 0, 0);
        tcase = 2; frame(1'b1, 0, 0, 50);

        for (int n = 0; n < N; n++) mem[n] = (n % 2 == 0) ? 2047 : -2047;
        tcase = 3; frame(1'b1, 0, 0, 0);

        fill_const(1000);
        tcase = 0; frame(1'b0, 100, 0, 0);
        tcase = 4; frame(1'b0, 0, 0, 0);
        tcase = 5; frame(1'b0, 0, 50, 0);

        // start and abort together while idle: start must be ignored
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);

        // async reset mid-frame, asserted just after a rising edge
        tcase = 0;
        start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (119) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fill_const(0);
        mem[0] = 2000;
        tcase = 6; frame(1'b0, 0, 0, 0);

        tcase = 0;
        for (int f = 0; f < 6; f++) begin
            for (int n = 0; n < N; n++) mem[n] = int'($urandom_range(0, 4095)) - 2048;
            frame(1'($urandom_range(0, 1)),
                  (f % 3 == 2) ? int'($urandom_range(2, 258)) : 0,
                  (f % 3 == 1) ? int'($urandom_range(2, 258)) : 0,
                  int'($urandom_range(2, 250)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
